vending_fsm_param: RTL and testbench
====================================

Name: vending_fsm_param

Overview:
Parametrised two-product vending controller with a credit accumulator, two coin denominations, change/refund dispensing and coin rejection. Successor to the fixed 3-coin coffee/sprite FSM. Coin pulses and button pulses arrive pre-synchronised and debounced. Outputs drive dispense solenoids, availability LEDs, a change-unit dispenser and the credit display decoder.

Parameters:
CREDIT_W, 4, width of credit register and o_credit
MAX_CREDIT, 9, maximum credit held; must be < 2**CREDIT_W
COIN_B_VAL, 5, value in units of i_coin_b (i_coin_a is always 1 unit)
PRICE_A, 2, price of product A (coffee) in units, 1..MAX_CREDIT
PRICE_B, 3, price of product B (sprite) in units, 1..MAX_CREDIT
AUTO_CHANGE, 0, 1 = return remaining credit automatically after every vend

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_coin_a  input  1  one-cycle pulse, 1-unit coin inserted
i_coin_b  input  1  one-cycle pulse, COIN_B_VAL-unit coin inserted
i_sel_a  input  1  one-cycle pulse, product A requested
i_sel_b  input  1  one-cycle pulse, product B requested
i_refund  input  1  one-cycle pulse, return all credit
o_vend_a  output  1  one-cycle pulse, dispense product A
o_vend_b  output  1  one-cycle pulse, dispense product B
o_change  output  1  one pulse per returned unit
o_coin_reject  output  1  one-cycle pulse, coin returned to the customer, no credit taken
o_deny  output  1  one-cycle pulse, selection refused for insufficient credit
o_led_a  output  1  credit >= PRICE_A and state is IDLE/HOLD
o_led_b  output  1  credit >= PRICE_B and state is IDLE/HOLD
o_busy  output  1  state is VEND or REFUND
o_credit  output  CREDIT_W  current credit

Behaviour:
- Reset: state IDLE, credit 0, every output 0. Reset mid-vend or mid-refund abandons the operation and drops credit to 0.
- All outputs are registered and reflect the state/credit after the clock edge. Input to output latency is 1 cycle.
- States:
  - IDLE: credit == 0.
  - HOLD: credit > 0.
  - VEND: single cycle. o_vend_a or o_vend_b is high.
  - REFUND: multi-cycle.
- Event priority in IDLE/HOLD, one event per cycle: i_refund > i_sel_a > i_sel_b > i_coin_a > i_coin_b. Any coin pulse not accepted in that cycle gives o_coin_reject=1 (lower-priority events lost, both coins rejected if both present with a button).
- Coin accept:
  - Accepted if credit+value <= MAX_CREDIT: credit += value, next state HOLD.
  - Otherwise: reject pulse, credit unchanged.
  - Both coins in the same cycle with no button: coin_a takes priority and coin_b is rejected.
- Select X (A or B):
  - credit >= PRICE_X: next cycle VEND with o_vend_x=1 and credit -= PRICE_X.
  - credit < PRICE_X: o_deny=1 and state unchanged.
- Leaving VEND:
  - credit == 0 -> IDLE.
  - AUTO_CHANGE=1 -> REFUND.
  - Otherwise -> HOLD.
- i_refund:
  - In IDLE: ignored.
  - In HOLD: -> REFUND.
- REFUND: o_change=1 and credit -= 1 each cycle. When credit reaches 0, -> IDLE. o_change pulse count equals the credit at entry.
- During VEND/REFUND:
  - Coins are rejected (o_coin_reject).
  - Selects and refund are ignored, with no o_deny.
- Credit arithmetic is done at CREDIT_W+1 bits for the overflow compare. Credit never exceeds MAX_CREDIT and never goes below 0.
- o_vend_a/b, o_change, o_coin_reject and o_deny are never asserted in IDLE except o_coin_reject for a coin rejected while idle.

Test Plan:
1. Reset, then coin_a x2, then sel_a -> o_credit 1,2. One cycle of o_vend_a. Credit 0, IDLE. o_led_a=1 while credit=2.
2. coin_b (5), then sel_b -> o_vend_b, credit 2, HOLD. Then i_refund -> exactly 2 o_change pulses on consecutive cycles, then IDLE, o_busy low.
3. coin_b, then coin_b again -> second gives o_coin_reject (10>9) and credit stays 5. Then coin_a x4 -> credit 9. Fifth coin_a is rejected.
4. credit 1, sel_b -> o_deny pulse, credit 1, no o_vend_b. Same cycle sel_a+sel_b with credit 3 -> only o_vend_a, credit 1.
5. AUTO_CHANGE=1: coin_b, sel_a -> o_vend_a, then 3 o_change pulses, then IDLE. A coin_a during REFUND -> o_coin_reject and the pulse count is unchanged.
6. rst_n asserted asynchronously mid-REFUND with credit 4 -> all outputs 0 and o_credit 0 immediately. After release, IDLE and no o_change.

Source files
------------

// File: rtl/vending_fsm_param.sv
// vending_fsm_param: two-product vending controller with a credit
// accumulator, two coin denominations, change/refund dispensing and coin
// rejection. Coin and button pulses arrive synchronised and debounced.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_coin_a / i_coin_b   coin pulses worth 1 / COIN_B_VAL units
//   i_sel_a / i_sel_b     product request pulses
//   i_refund              return-all-credit pulse
//   o_vend_a / o_vend_b   dispense pulses
//   o_change              one pulse per returned unit
//   o_coin_reject         coin returned, no credit taken
//   o_deny                selection refused, insufficient credit
//   o_led_a / o_led_b     product affordable while idle/holding
//   o_busy                vending or refunding
//   o_credit              current credit
// All outputs are registered and reflect state/credit after the edge.
module vending_fsm_param #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 9,
  parameter int COIN_B_VAL  = 5,
  parameter int PRICE_A     = 2,
  parameter int PRICE_B     = 3,
  parameter int AUTO_CHANGE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_coin_a,
  input  logic                i_coin_b,
  input  logic                i_sel_a,
  input  logic                i_sel_b,
  input  logic                i_refund,
  output logic                o_vend_a,
  output logic                o_vend_b,
  output logic                o_change,
  output logic                o_coin_reject,
  output logic                o_deny,
  output logic                o_led_a,
  output logic                o_led_b,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit
);

  typedef enum logic [1:0] {IDLE, HOLD, VEND, REFUND} state_t;

  localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   ONE_EXT   = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]   COIN_B_EXT = (CREDIT_W+1)'(COIN_B_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W-1:0] ONE_C     = CREDIT_W'(1);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [CREDIT_W:0]   sum_a, sum_b;
  logic                vend_a_nx, vend_b_nx, change_nx, reject_nx, deny_nx;
  logic                button, coin;

  // One extra bit so the overflow compare cannot wrap.
  assign sum_a  = {1'b0, o_credit} + ONE_EXT;
  assign sum_b  = {1'b0, o_credit} + COIN_B_EXT;
  assign button = i_refund | i_sel_a | i_sel_b;
  assign coin   = i_coin_a | i_coin_b;

  always_comb begin
    state_nx  = state;
    credit_nx = o_credit;
    vend_a_nx = 1'b0;
    vend_b_nx = 1'b0;
    change_nx = 1'b0;
    reject_nx = 1'b0;
    deny_nx   = 1'b0;
    case (state)
      VEND: begin
        reject_nx = coin;
        if (o_credit == '0) begin
          state_nx = IDLE;
        end else if (AUTO_CHANGE != 0) begin
          // First change unit is paid on the edge that enters REFUND so
          // o_change only ever appears while the busy state is visible.
          state_nx  = REFUND;
          change_nx = 1'b1;
          credit_nx = o_credit - ONE_C;
        end else begin
          state_nx = HOLD;
        end
      end
      REFUND: begin
        reject_nx = coin;
        if (o_credit != '0) begin
          change_nx = 1'b1;
          credit_nx = o_credit - ONE_C;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        if (button) begin
          // A button wins the cycle; any coin alongside it is handed back.
          reject_nx = coin;
          if (i_refund) begin
            if (state == HOLD) begin
              state_nx  = REFUND;
              change_nx = 1'b1;
              credit_nx = o_credit - ONE_C;
            end
          end else if (i_sel_a) begin
            if (o_credit >= PRICE_A_C) begin
              state_nx  = VEND;
              vend_a_nx = 1'b1;
              credit_nx = o_credit - PRICE_A_C;
            end else if (state == HOLD) begin
              deny_nx = 1'b1;
            end
          end else begin
            if (o_credit >= PRICE_B_C) begin
              state_nx  = VEND;
              vend_b_nx = 1'b1;
              credit_nx = o_credit - PRICE_B_C;
            end else if (state == HOLD) begin
              deny_nx = 1'b1;
            end
          end
        end else if (i_coin_a) begin
          if (sum_a <= MAX_EXT) begin
            credit_nx = sum_a[CREDIT_W-1:0];
            state_nx  = HOLD;
          end else begin
            reject_nx = 1'b1;
          end
          if (i_coin_b) reject_nx = 1'b1;
        end else if (i_coin_b) begin
          if (sum_b <= MAX_EXT) begin
            credit_nx = sum_b[CREDIT_W-1:0];
            state_nx  = HOLD;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_credit      <= '0;
      o_vend_a      <= 1'b0;
      o_vend_b      <= 1'b0;
      o_change      <= 1'b0;
      o_coin_reject <= 1'b0;
      o_deny        <= 1'b0;
      o_led_a       <= 1'b0;
      o_led_b       <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_nx;
      o_credit      <= credit_nx;
      o_vend_a      <= vend_a_nx;
      o_vend_b      <= vend_b_nx;
      o_change      <= change_nx;
      o_coin_reject <= reject_nx;
      o_deny        <= deny_nx;
      o_led_a       <= (state_nx == IDLE || state_nx == HOLD) && (credit_nx >= PRICE_A_C);
      o_led_b       <= (state_nx == IDLE || state_nx == HOLD) && (credit_nx >= PRICE_B_C);
      o_busy        <= (state_nx == VEND) || (state_nx == REFUND);
    end
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: two instances (manual and automatic change)
// share the same stimulus and are compared every cycle against a
// credit-arithmetic reference model.
module tb_vending_fsm_param;

  localparam int MAXC = 9;
  localparam int BVAL = 5;
  localparam int PA   = 2;
  localparam int PB   = 3;

  typedef struct packed {
    logic       vend_a, vend_b, change, reject, deny, led_a, led_b, busy;
    logic [3:0] credit;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin_a = 1'b0, coin_b = 1'b0, sel_a = 1'b0, sel_b = 1'b0, refund = 1'b0;

  logic va0, vb0, ch0, rj0, dn0, la0, lb0, bz0;
  logic va1, vb1, ch1, rj1, dn1, la1, lb1, bz1;
  logic [3:0] cr0, cr1;
  obs_t o0, o1;

  assign o0 = {va0, vb0, ch0, rj0, dn0, la0, lb0, bz0, cr0};
  assign o1 = {va1, vb1, ch1, rj1, dn1, la1, lb1, bz1, cr1};

  always #5 clk = ~clk;

  vending_fsm_param #(.CREDIT_W(4), .MAX_CREDIT(MAXC), .COIN_B_VAL(BVAL),
                      .PRICE_A(PA), .PRICE_B(PB), .AUTO_CHANGE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .i_coin_a(coin_a), .i_coin_b(coin_b),
    .i_sel_a(sel_a), .i_sel_b(sel_b), .i_refund(refund),
    .o_vend_a(va0), .o_vend_b(vb0), .o_change(ch0), .o_coin_reject(rj0),
    .o_deny(dn0), .o_led_a(la0), .o_led_b(lb0), .o_busy(bz0), .o_credit(cr0));

  vending_fsm_param #(.CREDIT_W(4), .MAX_CREDIT(MAXC), .COIN_B_VAL(BVAL),
                      .PRICE_A(PA), .PRICE_B(PB), .AUTO_CHANGE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .i_coin_a(coin_a), .i_coin_b(coin_b),
    .i_sel_a(sel_a), .i_sel_b(sel_b), .i_refund(refund),
    .o_vend_a(va1), .o_vend_b(vb1), .o_change(ch1), .o_coin_reject(rj1),
    .o_deny(dn1), .o_led_a(la1), .o_led_b(lb1), .o_busy(bz1), .o_credit(cr1));

  int vectors = 0;
  int miscompares = 0;

  // Model: credit as a plain integer plus what the machine is doing.
  // mode 0 = accepting coins/buttons, 1 = dispensing, 2 = paying change.
  int   mcredit[2];
  int   mmode[2];
  obs_t mexp[2];
  int   chg_cnt[2];

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_obs(int k, obs_t got, obs_t exp);
    string p = $sformatf("d%0d.", k);
    chk({p, "vend_a"}, 4'(got.vend_a), 4'(exp.vend_a));
    chk({p, "vend_b"}, 4'(got.vend_b), 4'(exp.vend_b));
    chk({p, "change"}, 4'(got.change), 4'(exp.change));
    chk({p, "reject"}, 4'(got.reject), 4'(exp.reject));
    chk({p, "deny"},   4'(got.deny),   4'(exp.deny));
    chk({p, "led_a"},  4'(got.led_a),  4'(exp.led_a));
    chk({p, "led_b"},  4'(got.led_b),  4'(exp.led_b));
    chk({p, "busy"},   4'(got.busy),   4'(exp.busy));
    chk({p, "credit"}, got.credit,     exp.credit);
  endtask

  task automatic model(int k, bit auto_chg, bit ca, bit cb, bit sa, bit sb, bit rf);
    int   c = mcredit[k];
    int   m = mmode[k];
    obs_t e = '0;
    bit   coin = ca | cb;
    if (m == 1) begin
      e.reject = coin;
      if (c == 0) m = 0;
      else if (auto_chg) begin m = 2; e.change = 1'b1; c--; end
      else m = 0;
    end else if (m == 2) begin
      e.reject = coin;
      if (c > 0) begin e.change = 1'b1; c--; end
      else m = 0;
    end else if (rf | sa | sb) begin
      e.reject = coin;
      if (rf) begin
        if (c > 0) begin m = 2; e.change = 1'b1; c--; end
      end else if (sa) begin
        if (c >= PA) begin m = 1; e.vend_a = 1'b1; c -= PA; end
        else if (c > 0) e.deny = 1'b1;
      end else begin
        if (c >= PB) begin m = 1; e.vend_b = 1'b1; c -= PB; end
        else if (c > 0) e.deny = 1'b1;
      end
    end else if (ca) begin
      if (c + 1 <= MAXC) c++; else e.reject = 1'b1;
      if (cb) e.reject = 1'b1;
    end else if (cb) begin
      if (c + BVAL <= MAXC) c += BVAL; else e.reject = 1'b1;
    end
    e.led_a  = (m == 0) && (c >= PA);
    e.led_b  = (m == 0) && (c >= PB);
    e.busy   = (m != 0);
    e.credit = 4'(c);
    mcredit[k] = c;
    mmode[k]   = m;
    mexp[k]    = e;
  endtask

  task automatic step(bit ca, bit cb, bit sa, bit sb, bit rf);
    coin_a = ca; coin_b = cb; sel_a = sa; sel_b = sb; refund = rf;
    @(posedge clk);
    #1;
    model(0, 1'b0, ca, cb, sa, sb, rf);
    model(1, 1'b1, ca, cb, sa, sb, rf);
    check_obs(0, o0, mexp[0]);
    check_obs(1, o1, mexp[1]);
    if (ch0 === 1'b1) chg_cnt[0]++;
    if (ch1 === 1'b1) chg_cnt[1]++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    step(0, 0, 0, 0, 1);
    idle(12);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcredit[k] = 0;
      mmode[k]   = 0;
      mexp[k]    = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    check_obs(0, o0, '0);
    check_obs(1, o1, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // coin_a twice then select A
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t1_credit2", cr0, 4'd2);
    chk("t1_led_a", 4'(la0), 4'd1);
    step(0, 0, 1, 0, 0);
    idle(2);

    // coin_b, select B, refund the remainder
    chg_cnt[0] = 0; chg_cnt[1] = 0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(3);
    chk("t2_change_count_d0", 4'(chg_cnt[0]), 4'd2);
    chk("t2_change_count_d1", 4'(chg_cnt[1]), 4'd2);

    // overflow rejection and filling to MAX_CREDIT
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("t3_credit_max", cr0, 4'd9);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    drain();

    // deny, then simultaneous selects
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t4_vend_a_only", 4'({va0, vb0}), 4'b0010);
    step(1, 1, 1, 0, 0);
    drain();

    // automatic change with a coin arriving mid-refund
    chg_cnt[1] = 0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(4);
    chk("t5_change_count_d1", 4'(chg_cnt[1]), 4'd3);
    drain();

    // asynchronous reset in the middle of a refund
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t6_refund_credit", cr0, 4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_obs(0, o0, '0);
    check_obs(1, o1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chg_cnt[0] = 0; chg_cnt[1] = 0;
    idle(4);
    chk("t6_no_change_after_reset", 4'(chg_cnt[0] + chg_cnt[1]), 4'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
